// File: rtl/i2c_master_wr.sv
// i2c_master_wr: single-clock I2C master issuing one 7-bit-addressed, two-byte
// write or read per request. SCL and SDA are driven open-drain: *_o are tied low
// and *_en_o pulls the line down when high.
//
// Optional build macro: I2C_MASTER_STRETCH_EN enables slave clock-stretch
// detection. When it is undefined, scl_i is ignored.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                request, accepted only when idle
//   rw_i, adress_i, data_i direction (1 = read), slave address, write word
//                          (data_i[15:8] is sent first); all latched at accept
//   sda_i, scl_i           bus line levels, synchronized before use
//   busy_o                 high from accept until the end of STOP
//   done_o                 one-clk pulse when the transaction ends
//   nack_o                 slave NACKed the address or a write byte
//   rd_data_o              read word, first byte in [15:8]
//   sda_o, scl_o           constant 0 (open-drain low level)
//   sda_en_o, scl_en_o     1 = pull the line low
module i2c_master_wr #(
  parameter int unsigned ClkDiv = 25  // clk cycles per SCL quarter period, >= 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        rw_i,
  input  logic [6:0]  adress_i,
  input  logic [15:0] data_i,
  input  logic        sda_i,
  input  logic        scl_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        nack_o,
  output logic [15:0] rd_data_o,
  output logic        sda_o,
  output logic        scl_o,
  output logic        sda_en_o,
  output logic        scl_en_o
);

  localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StAddr, StAack, StByte1, StAck1, StByte2, StAck2, StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      qtr_q;
  logic [2:0]      bit_q;
  logic            rw_q;
  logic [6:0]      adr_q;
  logic [15:0]     data_q;
  logic [15:0]     rx_q;
  logic [15:0]     rd_data_q;
  logic            nack_q;
  logic            done_q;
  logic [1:0]      sda_sync_q;

  logic       sda_s;
  logic       accept;
  logic       smp_clk;
  logic       smp_en;
  logic       stall;
  logic       qtr_end;
  logic       slot_end;
  logic       is_byte;
  logic [7:0] tx_byte;
  logic       tx_bit;
  logic       sda_en;
  logic       scl_en;

  assign sda_s = sda_sync_q[1];

  // A start request in the clk where done is high is dropped on purpose.
  assign accept  = (state_q == StIdle) && start_i && !done_q;
  // Last clk of q2: SDA is sampled here (and stretching is checked here).
  assign smp_clk = (state_q != StIdle) && (qtr_q == 2'd2) && (cnt_q == CntMax);
  assign is_byte = (state_q == StAddr) || (state_q == StByte1) || (state_q == StByte2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sda_sync_q <= 2'b11;
    end else begin
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef I2C_MASTER_STRETCH_EN
  logic [1:0] scl_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
    end
  end

  // We released SCL but it still reads low: a slave is stretching, so freeze.
  assign stall = smp_clk && !scl_sync_q[1] && !scl_en;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign stall      = 1'b0;
`endif

  assign smp_en   = smp_clk && !stall;
  assign qtr_end  = (state_q != StIdle) && (cnt_q == CntMax) && !stall;
  assign slot_end = qtr_end && (qtr_q == 2'd3);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Timing counters and datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd7;
      rw_q      <= 1'b0;
      adr_q     <= 7'd0;
      data_q    <= 16'd0;
      rx_q      <= 16'd0;
      rd_data_q <= 16'd0;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == StStop) && slot_end;
      if (accept) begin
        rw_q   <= rw_i;
        adr_q  <= adress_i;
        data_q <= data_i;
        nack_q <= 1'b0;
        cnt_q  <= '0;
        qtr_q  <= 2'd0;
        bit_q  <= 3'd7;
      end else if ((state_q != StIdle) && !stall) begin
        if (qtr_end) begin
          cnt_q <= '0;
          qtr_q <= qtr_q + 2'd1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        if (slot_end) begin
          bit_q <= (is_byte && (bit_q != 3'd0)) ? bit_q - 3'd1 : 3'd7;
        end
      end
      if (smp_en) begin
        // Read-mode ACK1/ACK2 are driven by us, so they never flag a NACK.
        if ((state_q == StAack) ||
            (!rw_q && ((state_q == StAck1) || (state_q == StAck2)))) begin
          nack_q <= nack_q | sda_s;
        end
        if (rw_q && ((state_q == StByte1) || (state_q == StByte2))) begin
          rx_q <= {rx_q[14:0], sda_s};
        end
      end
      if ((state_q == StStop) && slot_end && rw_q && !nack_q) begin
        rd_data_q <= rx_q;
      end
    end
  end

  // Next-state logic: transitions only at slot boundaries
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StStart;
      StStart: if (slot_end) state_d = StAddr;
      StAddr:  if (slot_end && (bit_q == 3'd0)) state_d = StAack;
      StAack:  if (slot_end) state_d = nack_q ? StStop : StByte1;
      StByte1: if (slot_end && (bit_q == 3'd0)) state_d = StAck1;
      StAck1:  if (slot_end) state_d = (!rw_q && nack_q) ? StStop : StByte2;
      StByte2: if (slot_end && (bit_q == 3'd0)) state_d = StAck2;
      StAck2:  if (slot_end) state_d = StStop;
      StStop:  if (slot_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    tx_byte = {adr_q, rw_q};
    unique case (state_q)
      StByte1: tx_byte = data_q[15:8];
      StByte2: tx_byte = data_q[7:0];
      default: tx_byte = {adr_q, rw_q};
    endcase
  end

  assign tx_bit = tx_byte[bit_q];

  always_comb begin
    sda_en = 1'b0;
    scl_en = 1'b0;
    unique case (state_q)
      StStart: sda_en = qtr_q[1];
      StAddr: begin
        scl_en = ~qtr_q[1];
        sda_en = ~tx_bit;
      end
      StByte1, StByte2: begin
        scl_en = ~qtr_q[1];
        sda_en = !rw_q && !tx_bit;
      end
      StAack, StAck2: scl_en = ~qtr_q[1];
      StAck1: begin
        scl_en = ~qtr_q[1];
        sda_en = rw_q;  // on a read we ACK the first byte
      end
      StStop: begin
        scl_en = ~qtr_q[1];
        sda_en = (qtr_q != 2'd3);
      end
      default: begin
        sda_en = 1'b0;
        scl_en = 1'b0;
      end
    endcase
  end

  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign nack_o    = nack_q;
  assign rd_data_o = rd_data_q;
  assign sda_o     = 1'b0;
  assign scl_o     = 1'b0;
  assign sda_en_o  = sda_en;
  assign scl_en_o  = scl_en;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Directed bench for i2c_master_wr with a bit-level slave model on the
// wired-AND bus. Bit slots are numbered by SCL falls/rises of the master:
// 1-8 address, 9 AACK, 10-17 byte 1, 18 ACK1, 19-26 byte 2, 27 ACK2, 28 STOP.
module tb_i2c_master_wr;

  localparam int unsigned ClkDiv = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        rw_i;
  logic [6:0]  adress_i;
  logic [15:0] data_i;
  logic        busy_o, done_o, nack_o, sda_o, scl_o, sda_en_o, scl_en_o;
  logic [15:0] rd_data_o;
  logic        sda_line, scl_line;

  // Slave model state
  logic        slv_clr;
  logic        slv_sda_low, slv_scl_low;
  logic        slv_ack_addr, slv_ack_data, cur_rw, stretch_en;
  logic [15:0] slv_rd;
  logic        scl_prev;
  logic [31:0] bitlog;
  int          falls, rises, done_cnt, viol, hold_cnt;
  logic        hold_on, hold_run;

  int cyc = 0;
  int t_acc;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sda_line = ~(sda_en_o | slv_sda_low);
  assign scl_line = ~(scl_en_o | slv_scl_low);

  i2c_master_wr #(.ClkDiv(ClkDiv)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start_i),
    .rw_i     (rw_i),
    .adress_i (adress_i),
    .data_i   (data_i),
    .sda_i    (sda_line),
    .scl_i    (scl_line),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .nack_o   (nack_o),
    .rd_data_o(rd_data_o),
    .sda_o    (sda_o),
    .scl_o    (scl_o),
    .sda_en_o (sda_en_o),
    .scl_en_o (scl_en_o)
  );

  function automatic logic slave_drive(input int f);
    if (f == 9) return slv_ack_addr;
    if (!cur_rw) return ((f == 18) || (f == 27)) ? slv_ack_data : 1'b0;
    if ((f >= 10) && (f <= 17)) return ~slv_rd[15 - (f - 10)];
    if ((f >= 19) && (f <= 26)) return ~slv_rd[7 - (f - 19)];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (slv_clr) begin
      falls <= 0; rises <= 0; bitlog <= '0; done_cnt <= 0; viol <= 0;
      slv_sda_low <= 1'b0; slv_scl_low <= 1'b0; scl_prev <= 1'b0;
      hold_on <= 1'b0; hold_run <= 1'b0; hold_cnt <= 0;
    end else begin
      scl_prev <= scl_en_o;
      if (done_o) done_cnt <= done_cnt + 1;
      if (!scl_prev && scl_en_o) begin
        falls       <= falls + 1;
        slv_sda_low <= slave_drive(falls + 1);
        if (stretch_en && (falls + 1 == 18)) begin
          hold_on     <= 1'b1;
          slv_scl_low <= 1'b1;
        end
      end
      if (scl_prev && !scl_en_o) begin
        rises <= rises + 1;
        if (rises < 31) bitlog[rises + 1] <= sda_line;
      end
      if (hold_on) begin
        if (hold_run && scl_en_o) viol <= viol + 1;
        if (hold_run || !scl_en_o) begin
          hold_run <= 1'b1;
          hold_cnt <= hold_cnt + 1;
          if (hold_cnt == 19) begin
            hold_on     <= 1'b0;
            hold_run    <= 1'b0;
            slv_scl_low <= 1'b0;
          end
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] get_byte(input int first);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7 - i] = bitlog[first + i];
    return b;
  endfunction

  task automatic slave_clear();
    slv_clr = 1'b1;
    @(negedge clk);
    slv_clr = 1'b0;
  endtask

  task automatic launch();
    start_i = 1'b1;
    @(negedge clk);
    t_acc   = cyc;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int poke, output int lat);
    int n = 0;
    while (!done_o && (n < 3000)) begin
      @(negedge clk);
      n++;
      start_i = (poke > 0) && (cyc - t_acc == poke);
    end
    start_i = 1'b0;
    if (!done_o) check_eq("done_timeout", 32'd0, 32'd1);
    lat = cyc - t_acc;
  endtask

  task automatic do_txn(input logic rw, input logic [6:0] a, input logic [15:0] d,
                        input int poke, output int lat);
    slave_clear();
    cur_rw   = rw;
    rw_i     = rw;
    adress_i = a;
    data_i   = d;
    launch();
    wait_done(poke, lat);
  endtask

  initial begin
    int lat;
    int n;
    rst_n = 1'b0; start_i = 1'b0; rw_i = 1'b0; adress_i = '0; data_i = '0;
    slv_clr = 1'b1; slv_ack_addr = 1'b1; slv_ack_data = 1'b1; cur_rw = 1'b0;
    stretch_en = 1'b0; slv_rd = 16'h0000;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_nack", nack_o, 0);
    check_eq("rst_rd_data", rd_data_o, 0);
    check_eq("rst_sda_en", sda_en_o, 0);
    check_eq("rst_scl_en", scl_en_o, 0);
    check_eq("rst_o_lines", {sda_o, scl_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write, slave ACKs everything
    do_txn(1'b0, 7'h27, 16'hA55A, 0, lat);
    check_eq("wr_latency", lat, 464);
    check_eq("wr_nack", nack_o, 0);
    check_eq("wr_addr_byte", get_byte(1), 8'h4E);
    check_eq("wr_byte1", get_byte(10), 8'hA5);
    check_eq("wr_byte2", get_byte(19), 8'h5A);
    check_eq("wr_rises", rises, 28);
    @(negedge clk);
    check_eq("wr_done_pulse", done_o, 0);
    check_eq("wr_busy_after", busy_o, 0);
    check_eq("wr_bus_released", {sda_line, scl_line}, 2'b11);

    // No slave: address NACK
    slv_ack_addr = 1'b0;
    do_txn(1'b0, 7'h27, 16'hA55A, 0, lat);
    check_eq("anack_latency", lat, 176);
    check_eq("anack_nack", nack_o, 1);
    check_eq("anack_rises", rises, 10);
    slv_ack_addr = 1'b1;

    // Read 0x12, 0x34
    slv_rd = 16'h1234;
    do_txn(1'b1, 7'h27, 16'h0000, 0, lat);
    check_eq("rd_latency", lat, 464);
    check_eq("rd_addr_byte", get_byte(1), 8'h4F);
    check_eq("rd_master_ack", bitlog[18], 0);
    check_eq("rd_master_nack", bitlog[27], 1);
    check_eq("rd_data", rd_data_o, 16'h1234);
    check_eq("rd_nack", nack_o, 0);

    // Write with slave NACK on byte 1
    slv_ack_data = 1'b0;
    do_txn(1'b0, 7'h27, 16'hA55A, 0, lat);
    check_eq("bnack_latency", lat, 320);
    check_eq("bnack_nack", nack_o, 1);
    check_eq("bnack_rises", rises, 19);
    slv_ack_data = 1'b1;

    // start pulsed at clk 100 is ignored; start at the done clk is ignored too
    do_txn(1'b0, 7'h27, 16'hA55A, 100, lat);
    check_eq("poke_latency", lat, 464);
    check_eq("poke_no_early_done", done_cnt, 0);
    check_eq("poke_nack_cleared", nack_o, 0);
    start_i = 1'b1;
    slv_clr = 1'b1;
    @(negedge clk);
    slv_clr = 1'b0;
    check_eq("start_at_done_ignored", busy_o, 0);
    check_eq("done_one_clk", done_o, 0);
    launch();
    check_eq("b2b_accepted", busy_o, 1);
    wait_done(0, lat);
    check_eq("b2b_latency", lat, 464);
    check_eq("b2b_byte2", get_byte(19), 8'h5A);

    // Reset in the middle of byte 1
    slave_clear();
    cur_rw = 1'b0; rw_i = 1'b0; adress_i = 7'h27; data_i = 16'hA55A;
    launch();
    n = 0;
    while ((falls < 12) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_reached_byte1", falls, 12);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_sda_en", sda_en_o, 0);
    check_eq("midrst_scl_en", scl_en_o, 0);
    check_eq("midrst_busy", busy_o, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midrst_no_done", done_cnt, 0);
    do_txn(1'b0, 7'h27, 16'hA55A, 0, lat);
    check_eq("postrst_latency", lat, 464);
    check_eq("postrst_byte1", get_byte(10), 8'hA5);
    check_eq("postrst_nack", nack_o, 0);

    // Slave stretches SCL for 20 clk in ACK1
    stretch_en = 1'b1;
    do_txn(1'b0, 7'h27, 16'hA55A, 0, lat);
    stretch_en = 1'b0;
`ifdef I2C_MASTER_STRETCH_EN
    check_eq("stretch_later", (lat >= 481), 1);
    check_eq("stretch_scl_held", viol, 0);
    check_eq("stretch_nack", nack_o, 0);
    check_eq("stretch_byte2", get_byte(19), 8'h5A);
`else
    check_eq("nostretch_latency", lat, 464);
`endif
    slave_clear();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
